imem_port_arbiter: RTL and testbench
====================================

Name: imem_port_arbiter

Overview:
- Shares the single asynchronous-read instruction ROM (`imem`, 2048 x 32, word address `pc[12:2]`) between two requesters: the CPU fetch stage (port 0) and the debug/trace readback port (port 1).
- Replaces the fixed fetch register in front of the ROM.
- Returns registered read data with one-cycle latency per port.
- Fixed priority to fetch, with a starvation counter that guarantees debug service.

Parameters:
- ADDR_W, 11, ROM word-address width; ROM depth = 2^ADDR_W words.
- MAX_WAIT, 4, number of consecutive cycles debug may lose arbitration before it is forced a grant (1..15).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset. Assertion (0) clears state immediately; release is synchronous to clk.
- f_req  in  1  fetch request.
- f_addr  in  32  fetch byte address (PC).
- f_flush  in  1  discard any in-flight fetch response (branch/jump redirect).
- f_gnt  out  1  fetch request accepted this cycle (combinational).
- f_rvalid  out  1  fetch response valid (registered).
- f_rdata  out  32  fetch instruction word (registered).
- f_err  out  1  accompanies f_rvalid; set when the fetch address was misaligned.
- d_req  in  1  debug request.
- d_addr  in  32  debug byte address.
- d_gnt  out  1  debug request accepted this cycle (combinational).
- d_rvalid  out  1  debug response valid (registered).
- d_rdata  out  32  debug read word (registered).
- rom_a  out  ADDR_W  ROM word address (combinational).
- rom_spo  in  32  ROM read data (combinational from rom_a).

Behaviour:
- Reset values: f_rvalid=0, d_rvalid=0, f_rdata=0, d_rdata=0, f_err=0, starvation counter=0. Gnt outputs are 0 while rst=0.
- Arbitration is combinational each cycle, at most one grant:
  - only f_req: f_gnt=1.
  - only d_req: d_gnt=1.
  - both, and wait_cnt < MAX_WAIT: f_gnt=1.
  - both, and wait_cnt == MAX_WAIT: d_gnt=1 (forced).
- rom_a:
  - f_addr[ADDR_W+1:2] when f_gnt=1.
  - d_addr[ADDR_W+1:2] when d_gnt=1.
  - otherwise it holds the last granted address (registered copy) to avoid spurious ROM toggling.
- Starvation counter wait_cnt (4 bits):
  - increments when d_req=1 and d_gnt=0.
  - clears on d_gnt=1, and clears when d_req=0.
  - saturates at MAX_WAIT.
- Latency: a grant in cycle N captures rom_spo at the edge ending cycle N.
  - The matching xx_rvalid is 1 for exactly cycle N+1.
  - xx_rdata is valid in cycle N+1 and holds until that port's next response.
- f_err:
  - registered with the fetch response; equals (f_addr[1:0] != 0) at grant.
  - rdata is still the word-truncated read.
  - Address bits above ADDR_W+1 are ignored (wrap modulo ROM size).
- Flush:
  - f_flush=1 in cycle N+1 forces f_rvalid=0 that cycle and drops the response; f_rdata is not updated by the dropped response.
  - A fetch requested in the same cycle as f_flush is granted normally; its response is not dropped.
- Debug responses are never affected by f_flush.
- Back-to-back grants on either port are allowed every cycle; throughput is 1 word/cycle total.
- Reset mid-operation: in-flight responses are discarded, and rvalid stays 0 on the first cycle after release.

Test Plan:
- Reset, then f_req=1 with f_addr=0x0000_0008 and ROM[2]=0x2008_0005 -> f_gnt=1 in the same cycle; f_rvalid=1 and f_rdata=0x2008_0005 in the next cycle; d_rvalid=0.
- f_req=1 and d_req=1 held continuously, MAX_WAIT=4 -> f_gnt for 4 cycles, then d_gnt in the 5th cycle; d_rvalid in the 6th; pattern repeats every 5 cycles; wait_cnt never exceeds 4.
- Fetch 0x0000_0010, then f_flush=1 in the response cycle -> f_rvalid=0; f_rdata retains the prior value; the following fetch returns normally.
- Fetch with f_addr=0x0000_0006 -> f_rvalid=1, f_err=1, f_rdata=ROM[1].
- f_addr=0x0000_2004 (above ROM range) -> rom_a=1 and data=ROM[1] (wrap); f_err=0.
- Assert rst=0 one cycle after a debug grant -> d_rvalid=0 immediately; all outputs at reset values; after release, no stale response appears.

Source files
------------

// File: rtl/imem_port_arbiter_if.sv
// imem_port_arbiter_if: fetch/debug request-response bus plus the async ROM read port.
interface imem_port_arbiter_if #(parameter int ADDR_W = 11);
   logic              f_req;
   logic [31:0]       f_addr;
   logic              f_flush;
   logic              f_gnt;
   logic              f_rvalid;
   logic [31:0]       f_rdata;
   logic              f_err;
   logic              d_req;
   logic [31:0]       d_addr;
   logic              d_gnt;
   logic              d_rvalid;
   logic [31:0]       d_rdata;
   logic [ADDR_W-1:0] rom_a;
   logic [31:0]       rom_spo;
   modport slave (
      input  f_req, f_addr, f_flush, d_req, d_addr, rom_spo,
      output f_gnt, f_rvalid, f_rdata, f_err, d_gnt, d_rvalid, d_rdata, rom_a
   );
   modport master (
      output f_req, f_addr, f_flush, d_req, d_addr, rom_spo,
      input  f_gnt, f_rvalid, f_rdata, f_err, d_gnt, d_rvalid, d_rdata, rom_a
   );
endinterface

// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares one async-read instruction ROM between fetch and debug,
// fetch-priority with a starvation bound on debug, one-cycle registered responses.
module imem_port_arbiter #(
   parameter int ADDR_W   = 11,
   parameter int MAX_WAIT = 4
) (
   input  logic                clk,
   input  logic                rst,
   imem_port_arbiter_if.slave  bus
);
   localparam logic [3:0] MAX = 4'(MAX_WAIT);
   logic [3:0]        wait_q, wait_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              f_rvalid_q, f_rvalid_d, d_rvalid_q, d_rvalid_d, f_err_q, f_err_d;
   logic [31:0]       f_resp_q, f_resp_d, f_rdata_q, f_rdata_d, d_rdata_q, d_rdata_d;
   logic              f_gnt, d_gnt, f_take;
   always_comb begin
      d_gnt      = rst && bus.d_req && (!bus.f_req || wait_q == MAX);
      f_gnt      = rst && bus.f_req && !d_gnt;
      f_take     = f_rvalid_q && !bus.f_flush;
      addr_d     = f_gnt ? bus.f_addr[ADDR_W+1:2] : d_gnt ? bus.d_addr[ADDR_W+1:2] : addr_q;
      wait_d     = (!bus.d_req || d_gnt) ? 4'd0 : (wait_q == MAX ? wait_q : wait_q + 4'd1);
      f_rvalid_d = f_gnt;
      d_rvalid_d = d_gnt;
      f_resp_d   = f_gnt ? bus.rom_spo : f_resp_q;
      f_err_d    = f_gnt ? (bus.f_addr[1:0] != 2'b00) : f_err_q;
      // a flushed response never reaches the delivered word
      f_rdata_d  = f_take ? f_resp_q : f_rdata_q;
      d_rdata_d  = d_gnt ? bus.rom_spo : d_rdata_q;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wait_q     <= '0;
         addr_q     <= '0;
         f_rvalid_q <= 1'b0;
         d_rvalid_q <= 1'b0;
         f_err_q    <= 1'b0;
         f_resp_q   <= '0;
         f_rdata_q  <= '0;
         d_rdata_q  <= '0;
      end else begin
         wait_q     <= wait_d;
         addr_q     <= addr_d;
         f_rvalid_q <= f_rvalid_d;
         d_rvalid_q <= d_rvalid_d;
         f_err_q    <= f_err_d;
         f_resp_q   <= f_resp_d;
         f_rdata_q  <= f_rdata_d;
         d_rdata_q  <= d_rdata_d;
      end
   end
   assign bus.f_gnt    = f_gnt;
   assign bus.d_gnt    = d_gnt;
   assign bus.rom_a    = addr_d;
   assign bus.f_rvalid = f_take;
   assign bus.f_rdata  = f_rdata_d;
   assign bus.f_err    = f_take && f_err_q;
   assign bus.d_rvalid = d_rvalid_q;
   assign bus.d_rdata  = d_rdata_q;
endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb_imem_port_arbiter: directed scenarios plus a randomized run against a
// transaction-level model of the arbiter (grant rule, pending responses, held data).
module tb_imem_port_arbiter;
   localparam int MAX_WAIT = 4;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int checks = 0;
   int failures = 0;
   logic [31:0] rom [2048];
   imem_port_arbiter_if #(.ADDR_W(11)) bus ();
   imem_port_arbiter #(.ADDR_W(11), .MAX_WAIT(MAX_WAIT)) dut (.clk(clk), .rst(rst), .bus(bus));
   assign bus.rom_spo = rom[bus.rom_a];
   always #5 clk = ~clk;

   task automatic step(input logic fr, input logic [31:0] fa, input logic ff,
                       input logic dr, input logic [31:0] da);
      @(negedge clk);
      bus.f_req = fr; bus.f_addr = fa; bus.f_flush = ff; bus.d_req = dr; bus.d_addr = da;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      bus.f_req = 0; bus.f_addr = 0; bus.f_flush = 0; bus.d_req = 0; bus.d_addr = 0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b0;
      bus.f_req = 1; bus.f_addr = 32'h8; bus.f_flush = 0; bus.d_req = 1; bus.d_addr = 32'h4;
      #1;
      checks++;
      if ({bus.f_gnt, bus.d_gnt} !== 2'b00) begin
         failures++; $display("FAIL reset_gnt got=%b exp=00", {bus.f_gnt, bus.d_gnt});
      end
      checks++;
      if ({bus.f_rvalid, bus.d_rvalid, bus.f_err} !== 3'b000) begin
         failures++; $display("FAIL reset_flags got=%b exp=000", {bus.f_rvalid, bus.d_rvalid, bus.f_err});
      end
      checks++;
      if ({bus.f_rdata, bus.d_rdata} !== 64'h0) begin
         failures++; $display("FAIL reset_rdata got=%h exp=0", {bus.f_rdata, bus.d_rdata});
      end
      do_reset();
   endtask

   task automatic test_single_fetch();
      step(1, 32'h8, 0, 0, 0);
      checks++;
      if ({bus.f_gnt, bus.d_gnt, bus.rom_a} !== {2'b10, 11'd2}) begin
         failures++; $display("FAIL fetch_gnt got=%b/%0d exp=10/2", {bus.f_gnt, bus.d_gnt}, bus.rom_a);
      end
      step(0, 0, 0, 0, 0);
      checks++;
      if ({bus.f_rvalid, bus.d_rvalid, bus.f_rdata} !== {2'b10, 32'h2008_0005}) begin
         failures++; $display("FAIL fetch_resp got=%b/%h exp=10/20080005", {bus.f_rvalid, bus.d_rvalid}, bus.f_rdata);
      end
   endtask

   task automatic test_starvation();
      logic prev_d = 0;
      logic [31:0] prev_da = 0;
      for (int i = 0; i < 15; i++) begin
         logic expd;
         expd = (i % 5 == 4);
         step(1, 32'(i * 4), 0, 1, 32'h100 + 32'(i * 4));
         checks++;
         if ({bus.f_gnt, bus.d_gnt} !== {!expd, expd}) begin
            failures++; $display("FAIL starve_gnt cyc=%0d got=%b exp=%b", i, {bus.f_gnt, bus.d_gnt}, {!expd, expd});
         end
         checks++;
         if (bus.d_rvalid !== prev_d) begin
            failures++; $display("FAIL starve_dvalid cyc=%0d got=%b exp=%b", i, bus.d_rvalid, prev_d);
         end
         prev_d = expd;
         if (expd) prev_da = 32'h100 + 32'(i * 4);
      end
      step(0, 0, 0, 0, 0);
      checks++;
      if ({bus.d_rvalid, bus.d_rdata} !== {1'b1, rom[prev_da[12:2]]}) begin
         failures++; $display("FAIL starve_ddata got=%b/%h exp=1/%h", bus.d_rvalid, bus.d_rdata, rom[prev_da[12:2]]);
      end
   endtask

   task automatic test_flush();
      step(1, 32'h20, 0, 0, 0);
      step(1, 32'h10, 0, 0, 0);
      checks++;
      if ({bus.f_rvalid, bus.f_rdata} !== {1'b1, rom[8]}) begin
         failures++; $display("FAIL flush_prior got=%b/%h exp=1/%h", bus.f_rvalid, bus.f_rdata, rom[8]);
      end
      step(1, 32'h14, 1, 0, 0);
      checks++;
      if ({bus.f_rvalid, bus.f_rdata, bus.f_gnt} !== {1'b0, rom[8], 1'b1}) begin
         failures++; $display("FAIL flush_drop got=%b/%h/%b exp=0/%h/1", bus.f_rvalid, bus.f_rdata, bus.f_gnt, rom[8]);
      end
      step(0, 0, 0, 0, 0);
      checks++;
      if ({bus.f_rvalid, bus.f_rdata} !== {1'b1, rom[5]}) begin
         failures++; $display("FAIL flush_next got=%b/%h exp=1/%h", bus.f_rvalid, bus.f_rdata, rom[5]);
      end
   endtask

   task automatic test_misaligned();
      step(1, 32'h6, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      checks++;
      if ({bus.f_rvalid, bus.f_err, bus.f_rdata} !== {2'b11, rom[1]}) begin
         failures++; $display("FAIL misaligned got=%b%b/%h exp=11/%h", bus.f_rvalid, bus.f_err, bus.f_rdata, rom[1]);
      end
   endtask

   task automatic test_wrap();
      step(1, 32'h2004, 0, 0, 0);
      checks++;
      if (bus.rom_a !== 11'd1) begin
         failures++; $display("FAIL wrap_rom_a got=%0d exp=1", bus.rom_a);
      end
      step(0, 0, 0, 0, 0);
      checks++;
      if ({bus.f_rvalid, bus.f_err, bus.f_rdata, bus.rom_a} !== {2'b10, rom[1], 11'd1}) begin
         failures++; $display("FAIL wrap_resp got=%b%b/%h/%0d exp=10/%h/1", bus.f_rvalid, bus.f_err, bus.f_rdata, bus.rom_a, rom[1]);
      end
   endtask

   task automatic test_reset_mid();
      step(0, 0, 0, 1, 32'h40);
      checks++;
      if (bus.d_gnt !== 1'b1) begin
         failures++; $display("FAIL rstmid_gnt got=%b exp=1", bus.d_gnt);
      end
      @(negedge clk);
      rst = 1'b0;
      bus.d_req = 0;
      #1;
      checks++;
      if ({bus.d_rvalid, bus.f_rvalid, bus.f_err, bus.d_rdata, bus.f_rdata} !== 35'h0) begin
         failures++; $display("FAIL rstmid_clear got=%b%b%b/%h/%h exp=000/0/0", bus.d_rvalid, bus.f_rvalid, bus.f_err, bus.d_rdata, bus.f_rdata);
      end
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step(0, 0, 0, 0, 0);
         checks++;
         if ({bus.d_rvalid, bus.f_rvalid, bus.d_rdata} !== 34'h0) begin
            failures++; $display("FAIL rstmid_stale cyc=%0d got=%b%b/%h exp=00/0", i, bus.d_rvalid, bus.f_rvalid, bus.d_rdata);
         end
      end
   endtask

   task automatic test_random();
      int losses = 0;
      logic pf = 0, pd = 0, perr = 0;
      logic [31:0] pfd = 0, pdd = 0, fheld = 0, dheld = 0;
      logic [10:0] last_a = 0;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         logic fr, dr, ff, fg, dg, deliver;
         logic [31:0] fa, da;
         logic [10:0] exp_a;
         fr = $urandom_range(0, 3) != 0;
         dr = $urandom_range(0, 2) != 0;
         ff = $urandom_range(0, 4) == 0;
         fa = $urandom_range(0, 32'h3fff);
         da = $urandom_range(0, 32'h3fff);
         step(fr, fa, ff, dr, da);
         dg = dr && (!fr || losses == MAX_WAIT);
         fg = fr && !dg;
         exp_a = fg ? fa[12:2] : dg ? da[12:2] : last_a;
         deliver = pf && !ff;
         if (deliver) fheld = pfd;
         if (pd) dheld = pdd;
         checks++;
         if ({bus.f_gnt, bus.d_gnt, bus.f_rvalid, bus.f_err, bus.d_rvalid} !== {fg, dg, deliver, deliver && perr, pd}) begin
            failures++; $display("FAIL rand_ctrl cyc=%0d got=%b exp=%b", i,
               {bus.f_gnt, bus.d_gnt, bus.f_rvalid, bus.f_err, bus.d_rvalid}, {fg, dg, deliver, deliver && perr, pd});
         end
         checks++;
         if (bus.rom_a !== exp_a) begin
            failures++; $display("FAIL rand_rom_a cyc=%0d got=%0d exp=%0d", i, bus.rom_a, exp_a);
         end
         checks++;
         if ({bus.f_rdata, bus.d_rdata} !== {fheld, dheld}) begin
            failures++; $display("FAIL rand_rdata cyc=%0d got=%h/%h exp=%h/%h", i, bus.f_rdata, bus.d_rdata, fheld, dheld);
         end
         pf = fg; pfd = rom[fa[12:2]]; perr = fa[1:0] != 2'b00;
         pd = dg; pdd = rom[da[12:2]];
         losses = (dr && !dg) ? ((losses == MAX_WAIT) ? losses : losses + 1) : 0;
         last_a = exp_a;
      end
   endtask

   initial begin
      for (int i = 0; i < 2048; i++) rom[i] = $urandom;
      rom[2] = 32'h2008_0005;
      bus.f_req = 0; bus.f_addr = 0; bus.f_flush = 0; bus.d_req = 0; bus.d_addr = 0;
      test_reset();
      test_single_fetch();
      test_starvation();
      test_flush();
      test_misaligned();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
